// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline register indices, hazard control bits and the stall/flush/forward
// controls exchanged between the datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] rs1_d_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_d_i;
    logic [REG_ADDR_WIDTH-1:0] rs1_e_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_e_i;
    logic [REG_ADDR_WIDTH-1:0] rd_e_i;
    logic                      load_e_i;
    logic                      pc_src_e_i;
    logic [REG_ADDR_WIDTH-1:0] rd_m_i;
    logic                      reg_write_m_i;
    logic [REG_ADDR_WIDTH-1:0] rd_w_i;
    logic                      reg_write_w_i;
    logic                      dmem_req_m_i;
    logic                      dmem_ready_m_i;
    logic                      stall_f_o;
    logic                      stall_d_o;
    logic                      stall_e_o;
    logic                      stall_m_o;
    logic                      flush_d_o;
    logic                      flush_e_o;
    logic [1:0]                fwd_a_e_o;
    logic [1:0]                fwd_b_e_o;

    modport master (
        output rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, load_e_i, pc_src_e_i,
               rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i, dmem_req_m_i, dmem_ready_m_i,
        input  stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o,
               fwd_a_e_o, fwd_b_e_o
    );

    modport slave (
        input  rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, load_e_i, pc_src_e_i,
               rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i, dmem_req_m_i, dmem_ready_m_i,
        output stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o,
               fwd_a_e_o, fwd_b_e_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding control with a RUN/REDIRECT/MEM_WAIT tracker.
// Define HAZARD_PERF_CNT_EN to add saturating stall/redirect/memory-wait counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH        = 5,
    parameter int REDIRECT_FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH             = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_ctrl_if.slave         hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt_o,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt_o,
    output logic [CNT_WIDTH-1:0] perf_memwait_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [1:0]                RC_INIT  = 2'(REDIRECT_FLUSH_CYCLES - 1);

    if (REDIRECT_FLUSH_CYCLES < 1 || REDIRECT_FLUSH_CYCLES > 3 || CNT_WIDTH < 1) begin : g_param_check
        $error("hazard_ctrl: parameter out of range");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_mem_wait;
    logic       w_load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        logic [1:0] sel;
        if (rs == ZERO_REG) begin
            sel = 2'b00;
        end else if (we_m && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign w_mem_wait = hz.dmem_req_m_i && !hz.dmem_ready_m_i;
    assign w_load_use = hz.load_e_i && (hz.rd_e_i != ZERO_REG) &&
                        ((hz.rd_e_i == hz.rs1_d_i) || (hz.rd_e_i == hz.rs2_d_i));

    // State and redirect-count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state; the redirect count is frozen across a memory wait so the flush resumes after it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else if (hz.pc_src_e_i && (REDIRECT_FLUSH_CYCLES > 1)) begin
                    w_state_nxt = ST_REDIRECT;
                    w_cnt_nxt   = RC_INIT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                if (w_mem_wait) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else begin
                    w_cnt_nxt   = r_cnt - 2'd1;
                    w_state_nxt = (r_cnt == 2'd1) ? ST_RUN : ST_REDIRECT;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_wait) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else begin
                    w_state_nxt = (r_cnt != 2'd0) ? ST_REDIRECT : ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Outputs; priority is reset, then memory wait, then redirect, then load-use.
    always_comb begin
        hz.stall_f_o = 1'b0;
        hz.stall_d_o = 1'b0;
        hz.stall_e_o = 1'b0;
        hz.stall_m_o = 1'b0;
        hz.flush_d_o = 1'b0;
        hz.flush_e_o = 1'b0;
        hz.fwd_a_e_o = 2'b00;
        hz.fwd_b_e_o = 2'b00;
        if (!rst_n) begin
            hz.flush_d_o = 1'b1;
            hz.flush_e_o = 1'b1;
        end else begin
            hz.fwd_a_e_o = fwd_sel(hz.rs1_e_i, hz.rd_m_i, hz.reg_write_m_i, hz.rd_w_i, hz.reg_write_w_i);
            hz.fwd_b_e_o = fwd_sel(hz.rs2_e_i, hz.rd_m_i, hz.reg_write_m_i, hz.rd_w_i, hz.reg_write_w_i);
            if (w_mem_wait) begin
                hz.stall_f_o = 1'b1;
                hz.stall_d_o = 1'b1;
                hz.stall_e_o = 1'b1;
                hz.stall_m_o = 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (hz.pc_src_e_i) begin
                            hz.flush_d_o = 1'b1;
                            hz.flush_e_o = 1'b1;
                        end else if (w_load_use) begin
                            hz.stall_f_o = 1'b1;
                            hz.stall_d_o = 1'b1;
                            hz.flush_e_o = 1'b1;
                        end else begin
                            hz.flush_e_o = 1'b0;
                        end
                    end
                    ST_REDIRECT: begin
                        hz.flush_d_o = 1'b1;
                        hz.flush_e_o = 1'b1;
                    end
                    ST_MEM_WAIT: begin
                        hz.stall_f_o = 1'b0;
                    end
                    default: begin
                        hz.stall_f_o = 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    logic w_redirect_evt;

    assign w_redirect_evt = (r_state == ST_RUN) && hz.pc_src_e_i && !w_mem_wait;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o   <= '0;
            perf_flush_cnt_o   <= '0;
            perf_memwait_cnt_o <= '0;
        end else begin
            if (hz.stall_d_o && (perf_stall_cnt_o != CNT_MAX)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + CNT_WIDTH'(1);
            end else begin
                perf_stall_cnt_o <= perf_stall_cnt_o;
            end
            if (w_redirect_evt && (perf_flush_cnt_o != CNT_MAX)) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + CNT_WIDTH'(1);
            end else begin
                perf_flush_cnt_o <= perf_flush_cnt_o;
            end
            if ((r_state == ST_MEM_WAIT) && (perf_memwait_cnt_o != CNT_MAX)) begin
                perf_memwait_cnt_o <= perf_memwait_cnt_o + CNT_WIDTH'(1);
            end else begin
                perf_memwait_cnt_o <= perf_memwait_cnt_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic against a
// behavioural model that tracks "last cycle was a memory wait" and "flush cycles still owed".
module tb_hazard_ctrl;
    localparam int RW  = 5;
    localparam int NFL = 2;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst_n;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(RW)) hif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;
    longint m_stall_n, m_flush_n, m_mw_n;
`endif

    hazard_ctrl #(
        .REG_ADDR_WIDTH(RW),
        .REDIRECT_FLUSH_CYCLES(NFL),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt_o(stall_cnt),
        .perf_flush_cnt_o(flush_cnt),
        .perf_memwait_cnt_o(memwait_cnt)
`endif
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit m_prev_mw    = 1'b0;
    int m_redir_left = 0;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (hif.reg_write_m_i && hif.rd_m_i == rs) return 2'b10;
        if (hif.reg_write_w_i && hif.rd_w_i == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        hif.rs1_d_i = '0; hif.rs2_d_i = '0; hif.rs1_e_i = '0; hif.rs2_e_i = '0;
        hif.rd_e_i = '0; hif.load_e_i = 1'b0; hif.pc_src_e_i = 1'b0;
        hif.rd_m_i = '0; hif.reg_write_m_i = 1'b0; hif.rd_w_i = '0; hif.reg_write_w_i = 1'b0;
        hif.dmem_req_m_i = 1'b0; hif.dmem_ready_m_i = 1'b0;
    endtask

    // Called at a negedge with inputs applied: checks outputs, then advances the model over one edge.
    task automatic step(input string tag);
        bit         mw, lu, redir_evt;
        int         nxt_left;
        logic [5:0] exp_ctrl;
        #1;
        mw = hif.dmem_req_m_i && !hif.dmem_ready_m_i;
        lu = hif.load_e_i && hif.rd_e_i != 0 &&
             (hif.rd_e_i == hif.rs1_d_i || hif.rd_e_i == hif.rs2_d_i);
        if (!rst_n) begin
            m_prev_mw    = 1'b0;
            m_redir_left = 0;
        end
        nxt_left  = m_redir_left;
        redir_evt = 1'b0;
        // bit order {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
        if (!rst_n)                exp_ctrl = 6'b000011;
        else if (mw)               exp_ctrl = 6'b111100;
        else if (m_prev_mw)        exp_ctrl = 6'b000000;
        else if (m_redir_left > 0) begin exp_ctrl = 6'b000011; nxt_left = m_redir_left - 1; end
        else if (hif.pc_src_e_i)   begin exp_ctrl = 6'b000011; nxt_left = NFL - 1; redir_evt = 1'b1; end
        else if (lu)               exp_ctrl = 6'b110001;
        else                       exp_ctrl = 6'b000000;
        check({tag, "/ctrl"}, {hif.stall_f_o, hif.stall_d_o, hif.stall_e_o, hif.stall_m_o,
                               hif.flush_d_o, hif.flush_e_o}, exp_ctrl);
        check({tag, "/fwd_a"}, {4'b0000, hif.fwd_a_e_o}, rst_n ? {4'b0000, fwd_ref(hif.rs1_e_i)} : 6'b000000);
        check({tag, "/fwd_b"}, {4'b0000, hif.fwd_b_e_o}, rst_n ? {4'b0000, fwd_ref(hif.rs2_e_i)} : 6'b000000);
        @(posedge clk);
        if (rst_n) begin
`ifdef HAZARD_PERF_CNT_EN
            m_stall_n += longint'(exp_ctrl[4]);
            m_flush_n += longint'(redir_evt);
            m_mw_n    += longint'(m_prev_mw);
`endif
            m_prev_mw    = mw;
            m_redir_left = nxt_left;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            m_stall_n = 0; m_flush_n = 0; m_mw_n = 0;
`endif
            m_prev_mw    = 1'b0;
            m_redir_left = 0;
        end
        @(negedge clk);
    endtask

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        m_stall_n = 0; m_flush_n = 0; m_mw_n = 0;
`endif
        rst_n = 1'b0;
        idle();
        // reset dominates a pending memory wait and a forwarding match
        hif.dmem_req_m_i = 1'b1; hif.rs1_e_i = 5'd3; hif.rd_m_i = 5'd3; hif.reg_write_m_i = 1'b1;
        @(negedge clk);
        step("reset0");
        step("reset1");
        idle();
        rst_n = 1'b1;
        step("idle");

        // forwarding priority
        hif.rs1_e_i = 5'd5; hif.rd_m_i = 5'd5; hif.reg_write_m_i = 1'b1;
        hif.rd_w_i = 5'd5; hif.reg_write_w_i = 1'b1; hif.rs2_e_i = 5'd9;
        step("fwd_m_wins");
        hif.reg_write_m_i = 1'b0; hif.rs2_e_i = 5'd5;
        step("fwd_w");
        hif.rs1_e_i = 5'd0; hif.rd_w_i = 5'd0; hif.rs2_e_i = 5'd0;
        step("fwd_zero");
        idle();

        // load-use
        hif.load_e_i = 1'b1; hif.rd_e_i = 5'd7; hif.rs2_d_i = 5'd7;
        step("lu_hit");
        hif.load_e_i = 1'b0;
        step("lu_clear");
        hif.load_e_i = 1'b1; hif.rd_e_i = 5'd0; hif.rs1_d_i = 5'd0; hif.rs2_d_i = 5'd0;
        step("lu_x0");
        idle();

        // redirect pulse: two flush cycles
        hif.pc_src_e_i = 1'b1;
        step("redir0");
        hif.pc_src_e_i = 1'b0;
        step("redir1");
        step("redir_done");

        // memory wait: three stall cycles, stalls drop on ready
        hif.dmem_req_m_i = 1'b1;
        for (int i = 0; i < 3; i++) step("memwait");
        hif.dmem_ready_m_i = 1'b1;
        step("mem_ready");
        idle();
        step("mem_after");

        // redirect with load-use, then memory wait interrupts the redirect
        hif.pc_src_e_i = 1'b1; hif.load_e_i = 1'b1; hif.rd_e_i = 5'd4; hif.rs1_d_i = 5'd4;
        step("prio_redir_lu");
        idle();
        hif.dmem_req_m_i = 1'b1;
        step("prio_mw0");
        step("prio_mw1");
        hif.dmem_ready_m_i = 1'b1;
        step("prio_ready");
        idle();
        step("prio_resume");
        step("prio_done");

        // reset in the middle of a memory wait
        hif.dmem_req_m_i = 1'b1;
        step("mw_pre_rst0");
        step("mw_pre_rst1");
        rst_n = 1'b0;
        step("mw_rst");
        rst_n = 1'b1;
        idle();
        step("post_rst");
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_rst", stall_cnt[5:0], 6'd0);
        check("perf_memwait_rst", memwait_cnt[5:0], 6'd0);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            hif.rs1_d_i = RW'($urandom_range(0, 3));
            hif.rs2_d_i = RW'($urandom_range(0, 3));
            hif.rs1_e_i = RW'($urandom_range(0, 3));
            hif.rs2_e_i = RW'($urandom_range(0, 3));
            hif.rd_e_i  = RW'($urandom_range(0, 3));
            hif.rd_m_i  = RW'($urandom_range(0, 3));
            hif.rd_w_i  = RW'($urandom_range(0, 3));
            hif.load_e_i       = 1'($urandom_range(0, 1));
            hif.reg_write_m_i  = 1'($urandom_range(0, 1));
            hif.reg_write_w_i  = 1'($urandom_range(0, 1));
            hif.pc_src_e_i     = ($urandom_range(0, 5) == 0);
            hif.dmem_req_m_i   = ($urandom_range(0, 3) == 0);
            hif.dmem_ready_m_i = 1'($urandom_range(0, 1));
            rst_n              = ($urandom_range(0, 99) != 0);
            step("rand");
        end
        rst_n = 1'b1;
        idle();
        step("final");
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", stall_cnt[5:0], 6'(m_stall_n));
        check("perf_flush", flush_cnt[5:0], 6'(m_flush_n));
        check("perf_memwait", memwait_cnt[5:0], 6'(m_mw_n));
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Drives the stall/enable and clear inputs of the fetch/decode, decode/execute and execute/memory pipeline registers.
- Generates execute-stage operand forwarding selects.
- Tracks multi-cycle hazards in a small registered state machine:
  - load-use interlock
  - branch/jump redirect flush
  - data-memory wait freeze
- Sits beside the datapath in the top-level core; consumes register indices and control bits carried by the pipeline registers.

Parameters:
- REG_ADDR_WIDTH, 5, width of register index fields rs1/rs2/rd.
- REDIRECT_FLUSH_CYCLES, 1, cycles D and E are cleared after a taken branch/jump (range 1-3).
- CNT_WIDTH, 32, width of optional performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_d_i  in  REG_ADDR_WIDTH  decode-stage source 1 index.
- rs2_d_i  in  REG_ADDR_WIDTH  decode-stage source 2 index.
- rs1_e_i  in  REG_ADDR_WIDTH  execute-stage source 1 index.
- rs2_e_i  in  REG_ADDR_WIDTH  execute-stage source 2 index.
- rd_e_i  in  REG_ADDR_WIDTH  execute-stage destination.
- load_e_i  in  1  execute-stage instruction is a load (res_src==01).
- pc_src_e_i  in  1  taken branch or jump resolved in execute.
- rd_m_i  in  REG_ADDR_WIDTH  memory-stage destination.
- reg_write_m_i  in  1  memory-stage writes register file.
- rd_w_i  in  REG_ADDR_WIDTH  writeback-stage destination.
- reg_write_w_i  in  1  writeback-stage writes register file.
- dmem_req_m_i  in  1  memory stage has an outstanding data access.
- dmem_ready_m_i  in  1  data memory completes access this cycle.
- stall_f_o  out  1  hold PC.
- stall_d_o  out  1  drives en of F/D register; 1 = hold.
- stall_e_o  out  1  drives en of D/E register; 1 = hold.
- stall_m_o  out  1  drives en of E/M register; 1 = hold.
- flush_d_o  out  1  clr of F/D register.
- flush_e_o  out  1  clr of D/E register.
- fwd_a_e_o  out  2  operand A select: 00 regfile, 10 from M, 01 from W.
- fwd_b_e_o  out  2  operand B select, same encoding.

Behaviour:
- State register (async reset to RUN); states: RUN, REDIRECT, MEM_WAIT.
- Outputs are combinational from state and inputs; no added latency.
- While rst_n=0: state=RUN, redirect counter=0.
- Outputs while rst_n=0:
  - flush_d_o=1, flush_e_o=1
  - all stalls=0
  - fwd selects=00
- Forwarding, per operand (rs != 0):
  - M match wins if reg_write_m_i && rd_m_i==rs.
  - Else W match if reg_write_w_i && rd_w_i==rs.
  - Else 00.
  - rs==0 always gives 00.
- Load-use, in RUN only: load_e_i && rd_e_i!=0 && (rd_e_i==rs1_d_i || rd_e_i==rs2_d_i):
  - stall_f_o=1, stall_d_o=1, flush_e_o=1 for exactly that cycle.
  - No state change; the condition clears naturally next cycle.
- Redirect, pc_src_e_i in RUN:
  - flush_d_o=1, flush_e_o=1 this cycle.
  - If REDIRECT_FLUSH_CYCLES>1: enter REDIRECT with counter = REDIRECT_FLUSH_CYCLES-1.
  - In REDIRECT: flush_d_o=flush_e_o=1; counter decrements each cycle; return to RUN when the counter reaches 1→0.
  - pc_src_e_i while in REDIRECT is ignored, because E is already flushed.
- Memory wait: dmem_req_m_i && !dmem_ready_m_i in any state:
  - Enter MEM_WAIT; stall_f/d/e/m_o=1; no flushes.
  - Forwarding selects are still computed.
  - Leave to RUN in the cycle after dmem_ready_m_i=1; stalls drop in the ready cycle itself.
  - An interrupted REDIRECT count is saved and resumed after MEM_WAIT.
- Simultaneous-event priority: MEM_WAIT > redirect > load-use.
  - Redirect + load-use in the same cycle: redirect flushes apply and stall_f_o/stall_d_o=0.
  - A flush and a stall are never asserted on the same register in the same cycle.
- Async reset mid-MEM_WAIT or mid-REDIRECT returns to RUN immediately.

Optional Feature:
- HAZARD_PERF_CNT_EN defined adds three output ports, each CNT_WIDTH wide, async reset to 0, saturating at all-ones:
  - perf_stall_cnt_o: cycles with stall_d_o=1.
  - perf_flush_cnt_o: redirect events.
  - perf_memwait_cnt_o: MEM_WAIT cycles.
- Undefined: ports and counters are absent.

Test Plan:
- Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> fwd_a=10; clear reg_write_m -> fwd_a=01; rs1_e=0 -> fwd_a=00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle only; rd_e=0 -> no stall.
- Redirect with REDIRECT_FLUSH_CYCLES=2: pulse pc_src_e one cycle -> flush_d=flush_e=1 for exactly 2 cycles, then 0.
- Memory wait: dmem_req=1, ready low 3 cycles then high -> all four stalls high 3 cycles, low in the ready cycle; state RUN next.
- Priority: pc_src_e=1 and load-use together -> flushes only, stall_d=0; then dmem_req stall during REDIRECT -> remaining flush cycles resume after ready.
- Reset: drop rst_n mid-MEM_WAIT -> stalls go 0 and flush_d/flush_e go 1 immediately; after release, RUN with counters (if HAZARD_PERF_CNT_EN) at 0.
